dht_responder: RTL and testbench

Emulates the sensor end of the DHT11-style single-wire protocol.
- Detects a host start pulse on the shared open-drain line.
- Answers with the 80 µs low / 80 µs high presence pulse, then a 40-bit frame: humidity, temperature and checksum.
- Sits on the Altera DE2 board as a loopback target for the team's one-wire host and I2C display path; also serves as a simulation model.

---
 rtl/dht_pkg.sv | 43 ++++
 rtl/dht_responder_if.sv | 13 +
 rtl/dht_sync.sv | 22 ++
 rtl/dht_responder.sv | 156 +++++++++++++++
 tb/tb_dht_responder.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dht_pkg.sv
// dht_pkg: shared types, protocol timings and checksum helper for the DHT responder.
package dht_pkg;

    localparam int unsigned FRAME_W   = 40;
    localparam int unsigned CNT_W     = 21;
    localparam int unsigned BIT_IDX_W = 6;

    // Protocol phase lengths in microseconds
    localparam int unsigned T_RESP_WAIT_US = 30;
    localparam int unsigned T_RESP_LOW_US  = 80;
    localparam int unsigned T_RESP_HIGH_US = 80;
    localparam int unsigned T_BIT_LOW_US   = 50;
    localparam int unsigned T_BIT0_HIGH_US = 27;
    localparam int unsigned T_BIT1_HIGH_US = 70;
    localparam int unsigned T_TAIL_US      = 50;
    localparam int unsigned T_START_MIN_US = 18000;
    localparam int unsigned T_START_ERR_US = 1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESP_WAIT,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_TAIL
    } dht_state_e;

    typedef struct packed {
        logic [7:0] rh_int;
        logic [7:0] rh_dec;
        logic [7:0] temp_int;
        logic [7:0] temp_dec;
    } dht_payload_t;

    // Byte-sum checksum: 10-bit sum truncated to 8 bits
    function automatic logic [7:0] dht_chk(input dht_payload_t p);
        logic [9:0] sum;
        sum = 10'(p.rh_int) + 10'(p.rh_dec) + 10'(p.temp_int) + 10'(p.temp_dec);
        return sum[7:0];
    endfunction

endpackage

// File: rtl/dht_responder_if.sv
// dht_responder_if: payload inputs and status outputs of the DHT responder.
interface dht_responder_if;
    import dht_pkg::*;

    dht_payload_t payload;
    logic         busy;
    logic         frame_done;
    logic         start_err;

    modport master (output payload, input busy, frame_done, start_err);
    modport slave  (input payload, output busy, frame_done, start_err);

endinterface

// File: rtl/dht_sync.sv
// dht_sync: two-flop synchronizer for the single-wire line; resets to idle-high.
module dht_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous line level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dht_responder.sv
// dht_responder: sensor end of the DHT11-style single-wire protocol.
// Detects a host start pulse, answers with the presence pulse and sends a
// 40-bit frame {rh_int, rh_dec, temp_int, temp_dec, chk}, MSB first.
// Optional build macro DHT_RESP_FAULT_EN adds fault_chk, which corrupts the
// transmitted checksum (chk ^ 8'h01) when sampled high at start acceptance.
module dht_responder
    import dht_pkg::*;
#(
    parameter int unsigned CLK_1US      = 50,
    parameter int unsigned START_MIN_US = T_START_MIN_US,
    parameter int unsigned START_ERR_US = T_START_ERR_US
) (
    input  logic            clk,
    input  logic            rst,
    inout  wire             dht_io,
`ifdef DHT_RESP_FAULT_EN
    input  logic            fault_chk,
`endif
    dht_responder_if.slave  bus
);

    // Phase end values: a phase ends when cnt equals duration-1
    localparam logic [CNT_W-1:0] RESP_WAIT_LAST = CNT_W'(T_RESP_WAIT_US * CLK_1US - 1);
    localparam logic [CNT_W-1:0] RESP_LOW_LAST  = CNT_W'(T_RESP_LOW_US  * CLK_1US - 1);
    localparam logic [CNT_W-1:0] RESP_HIGH_LAST = CNT_W'(T_RESP_HIGH_US * CLK_1US - 1);
    localparam logic [CNT_W-1:0] BIT_LOW_LAST   = CNT_W'(T_BIT_LOW_US   * CLK_1US - 1);
    localparam logic [CNT_W-1:0] BIT0_LAST      = CNT_W'(T_BIT0_HIGH_US * CLK_1US - 1);
    localparam logic [CNT_W-1:0] BIT1_LAST      = CNT_W'(T_BIT1_HIGH_US * CLK_1US - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST      = CNT_W'(T_TAIL_US      * CLK_1US - 1);
    localparam logic [CNT_W-1:0] START_MIN_CYC  = CNT_W'(START_MIN_US * CLK_1US);
    localparam logic [CNT_W-1:0] START_ERR_CYC  = CNT_W'(START_ERR_US * CLK_1US);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT   = BIT_IDX_W'(FRAME_W - 1);

    dht_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc, phase_last;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic                 oe_q, oe_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 start_err_q, start_err_d;
    logic                 line_s;
    logic                 phase_end;
    logic [7:0]           chk_tx;

    dht_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (dht_io),
        .q   (line_s)
    );

    // Open-drain driver: pull low or release
    assign dht_io         = oe_q ? 1'b0 : 1'bz;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.start_err  = start_err_q;

    // Checksum to be latched at start acceptance
    always_comb begin
        chk_tx = dht_chk(bus.payload);
`ifdef DHT_RESP_FAULT_EN
        chk_tx = chk_tx ^ {7'b0, fault_chk};
`endif
    end

    // Saturating increment and per-state phase length
    always_comb begin
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        phase_last = '0;
        unique case (state_q)
            ST_RESP_WAIT: phase_last = RESP_WAIT_LAST;
            ST_RESP_LOW:  phase_last = RESP_LOW_LAST;
            ST_RESP_HIGH: phase_last = RESP_HIGH_LAST;
            ST_BIT_LOW:   phase_last = BIT_LOW_LAST;
            ST_BIT_HIGH:  phase_last = shreg_q[FRAME_W-1] ? BIT1_LAST : BIT0_LAST;
            ST_TAIL:      phase_last = TAIL_LAST;
            default:      phase_last = '0;
        endcase
        phase_end = (cnt_q == phase_last);
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_inc;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        frame_done_d = 1'b0;
        start_err_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (line_s) begin
                    cnt_d = '0;
                    if (cnt_q >= START_MIN_CYC) begin
                        state_d   = ST_RESP_WAIT;
                        shreg_d   = {bus.payload, chk_tx};
                        bit_idx_d = '0;
                    end else if (cnt_q >= START_ERR_CYC) begin
                        start_err_d = 1'b1;
                    end
                end
            end
            ST_RESP_WAIT: if (phase_end) state_d = ST_RESP_LOW;
            ST_RESP_LOW:  if (phase_end) state_d = ST_RESP_HIGH;
            ST_RESP_HIGH: if (phase_end) state_d = ST_BIT_LOW;
            ST_BIT_LOW:   if (phase_end) state_d = ST_BIT_HIGH;
            ST_BIT_HIGH: begin
                if (phase_end) begin
                    shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
                    bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    state_d   = (bit_idx_q == LAST_BIT) ? ST_TAIL : ST_BIT_LOW;
                end
            end
            ST_TAIL: begin
                if (phase_end) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        oe_d   = (state_d == ST_RESP_LOW) || (state_d == ST_BIT_LOW) || (state_d == ST_TAIL);
        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            oe_q         <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            start_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            oe_q         <= oe_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            start_err_q  <= start_err_d;
        end
    end

endmodule

// File: tb/tb_dht_responder.sv
// tb_dht_responder: host-side stimulus and frame decoder for dht_responder.
// Start thresholds are scaled down (1 tick per us, 1.8 ms start, 0.1 ms error
// floor) so each frame fits a short run; protocol phase lengths are unchanged.
`timescale 1ns/1ps
module tb_dht_responder;
    import dht_pkg::*;

    localparam int C    = 1;
    localparam int SMIN = 1800;
    localparam int SERR = 100;
    localparam int HOST_START = 2000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic host_low = 1'b0;
    wire  dht_line;

    int checks = 0;
    int errors = 0;

    int run_len[$];
    int fd_count, fd_at, se_count, busy_seen, busy_end;

    assign dht_line = host_low ? 1'b0 : 1'bz;
    pullup (dht_line);

    dht_responder_if bus ();
`ifdef DHT_RESP_FAULT_EN
    logic fault_chk = 1'b0;
`endif

    dht_responder #(.CLK_1US(C), .START_MIN_US(SMIN), .START_ERR_US(SERR)) dut (
        .clk       (clk),
        .rst       (rst),
        .dht_io    (dht_line),
`ifdef DHT_RESP_FAULT_EN
        .fault_chk (fault_chk),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic check_frame(input string tag, input logic [FRAME_W-1:0] obs,
                               input logic [FRAME_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %010h expected %010h", tag, obs, exp);
        end
    endtask

    // Reference frame: four payload bytes followed by their byte-sum mod 256
    function automatic logic [FRAME_W-1:0] model_frame(input int a, b, c, d, input bit fault);
        int s;
        s = (a + b + c + d) % 256;
        if (fault) s = s ^ 1;
        return {8'(a), 8'(b), 8'(c), 8'(d), 8'(s)};
    endfunction

    task automatic set_payload(input int a, b, c, d);
        bus.payload.rh_int   = 8'(a);
        bus.payload.rh_dec   = 8'(b);
        bus.payload.temp_int = 8'(c);
        bus.payload.temp_dec = 8'(d);
    endtask

    // Host pulls the line low for low_cycles clocks, then releases it
    task automatic host_start(input int low_cycles);
        @(posedge clk);
        #1 host_low = 1'b1;
        repeat (low_cycles) @(posedge clk);
        #1 host_low = 1'b0;
    endtask

    // Record line run lengths and status pulses after release
    task automatic capture(input int budget, input int change_at);
        logic prev;
        int   len;
        run_len.delete();
        fd_count = 0; fd_at = -1; se_count = 0; busy_seen = 0;
        prev = 1'b1;
        len  = 0;
        for (int j = 1; j <= budget; j++) begin
            @(posedge clk);
            #1;
            if (j == change_at)
                set_payload($urandom_range(0, 255), $urandom_range(0, 255),
                            $urandom_range(0, 255), $urandom_range(0, 255));
            if (bus.frame_done === 1'b1) begin
                fd_count++;
                if (fd_at < 0) fd_at = j;
            end
            if (bus.start_err === 1'b1) se_count++;
            if (bus.busy === 1'b1) busy_seen = 1;
            if (dht_line !== prev) begin
                run_len.push_back(len);
                prev = dht_line;
                len  = 1;
            end else begin
                len++;
            end
            if (fd_at >= 0 && j >= fd_at + 20) break;
        end
        run_len.push_back(len);
        busy_end = (bus.busy === 1'b1) ? 1 : 0;
    endtask

    // Decode the recorded waveform and compare with the reference frame
    task automatic analyse(input string name, input logic [FRAME_W-1:0] exp);
        logic [FRAME_W-1:0] dec;
        int bad, total, w;
        dec = '0;
        check({name, "_runs"}, run_len.size(), 85);
        if (run_len.size() >= 85) begin
            check_range({name, "_presence_delay"}, run_len[0] + 1, 30*C + 2, 30*C + 4);
            check_range({name, "_presence_low"}, run_len[1], 80*C - 1, 80*C + 1);
            check_range({name, "_presence_high"}, run_len[2], 80*C - 1, 80*C + 1);
            bad   = 0;
            total = 30 + 80 + 80 + 50;
            for (int i = 0; i < 40; i++) begin
                w = exp[39-i] ? 70 : 27;
                total += 50 + w;
                if (run_len[3+2*i] < 50*C - 1 || run_len[3+2*i] > 50*C + 1) bad++;
                if (run_len[4+2*i] < w*C - 1 || run_len[4+2*i] > w*C + 1) bad++;
                dec[39-i] = (run_len[4+2*i] > 48*C);
            end
            check({name, "_width_errs"}, bad, 0);
            check_frame({name, "_frame"}, dec, exp);
            check_range({name, "_tail_low"}, run_len[83], 50*C - 1, 50*C + 1);
            check_range({name, "_frame_time"}, fd_at, total*C + 2, total*C + 4);
        end
        check({name, "_frame_done_cnt"}, fd_count, 1);
        check({name, "_busy_seen"}, busy_seen, 1);
        check({name, "_busy_end"}, busy_end, 0);
    endtask

    task automatic do_frame(input string name, input int a, b, c, d,
                            input bit fault, input int change_at);
        set_payload(a, b, c, d);
`ifdef DHT_RESP_FAULT_EN
        fault_chk = fault;
`endif
        host_start(HOST_START);
        capture(6000, change_at);
        analyse(name, model_frame(a, b, c, d, fault));
    endtask

    initial begin
        logic [FRAME_W-1:0] f;
        int ra, rb, rc, rd, k;

        set_payload(0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        check("rst_start_err", int'(bus.start_err), 0);
        check("rst_line", int'(dht_line), 1);
        rst = 1'b1;
        repeat (3) @(posedge clk);

        // Directed frame from the reference payload
        do_frame("base", 55, 0, 27, 3, 1'b0, 0);
        f = model_frame(55, 0, 27, 3, 1'b0);
        check_frame("base_const", f, 40'h37_00_1B_03_55);

        // Too-short start: error pulse, no response
        host_start(500);
        capture(300, 0);
        check("short_start_err", se_count, 1);
        check("short_runs", run_len.size(), 1);
        check("short_busy", busy_seen, 0);

        // Glitch: below the error floor, nothing happens
        host_start(20);
        capture(300, 0);
        check("glitch_start_err", se_count, 0);
        check("glitch_runs", run_len.size(), 1);

        // Checksum wrap
        do_frame("wrap", 200, 100, 50, 10, 1'b0, 0);
        check("wrap_chk", int'(model_frame(200, 100, 50, 10, 1'b0) & 40'hFF), 104);

        // Random payloads
        for (int n = 0; n < 2; n++) begin
            do_frame($sformatf("rand%0d", n), $urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 0);
        end

        // Payload inputs change mid-frame
        do_frame("latch", $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 1000);

        // Reset during bit 17
        ra = $urandom_range(0, 255); rb = $urandom_range(0, 255);
        rc = $urandom_range(0, 255); rd = $urandom_range(0, 255);
        set_payload(ra, rb, rc, rd);
`ifdef DHT_RESP_FAULT_EN
        fault_chk = 1'b0;
`endif
        f = model_frame(ra, rb, rc, rd, 1'b0);
        k = 3 + 30*C + 160*C;
        for (int i = 0; i < 17; i++) k += (50 + (f[39-i] ? 70 : 27)) * C;
        host_start(HOST_START);
        repeat (k + 10) @(posedge clk);
        #1;
        check("midrst_pre_low", int'(dht_line), 0);
        rst = 1'b0;
        #1;
        check("midrst_line", int'(dht_line), 1);
        check("midrst_busy", int'(bus.busy), 0);
        repeat (5) @(posedge clk);
        #1;
        check("midrst_hold_line", int'(dht_line), 1);
        check("midrst_hold_fd", int'(bus.frame_done), 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        do_frame("after_rst", $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 0);

`ifdef DHT_RESP_FAULT_EN
        // Corrupted checksum
        do_frame("fault", 55, 0, 27, 3, 1'b1, 0);
        check("fault_chk_const", int'(model_frame(55, 0, 27, 3, 1'b1) & 40'hFF), 8'h54);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
